adc_multi_reader: RTL and testbench
===================================

ADC_MULTI_READER -- requirements
Module: adc_multi_reader

Interface
REQ-001 SHALL have parameter NCH, default 2: number of ADC serial data lanes (1-8).
REQ-002 SHALL have parameter NBITS, default 16: bits per conversion per lane (8-18).
REQ-003 SHALL have parameter SCLK_DIV, default 2: CLK cycles per SCLK half-period (>=1).
REQ-004 SHALL have parameter CNV_CYC, default 4: CLK cycles CNVST_ADC is held low.
REQ-005 SHALL have parameter BUSY_TMO, default 255: CLK cycles allowed in each BUSY wait before timeout.
REQ-006 SHALL have parameter AVG_LOG2, default 2: log2 of conversions averaged per result (0-4).
REQ-007 SHALL have port CLK, input, 1: single system clock, rising-edge.
REQ-008 SHALL have port RST, input, 1: asynchronous, active-high reset.
REQ-009 SHALL have port start, input, 1: one-cycle request for one averaged result.
REQ-010 SHALL have port CNVST_ADC, output, 1: conversion start, active low.
REQ-011 SHALL have port BUSY_ADC, input, 1: ADC converting, active high.
REQ-012 SHALL have port CS_ADC, output, 1: ADC chip select, active low.
REQ-013 SHALL have port SCLK_ADC, output, 1: serial clock, idle high.
REQ-014 SHALL have port DOUT_ADC, input, NCH: serial data lanes; lane i on bit i.
REQ-015 SHALL have port data, output, NCH*NBITS: results; lane i at bits [i*NBITS +: NBITS].
REQ-016 SHALL have port data_valid, output, 1: one-cycle pulse when data updates.
REQ-017 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-018 SHALL have port timeout, output, 1: sticky flag, BUSY wait expired.

Function
REQ-019 SHALL implement states IDLE, CONV, WAIT_HI, WAIT_LO, SHIFT, ACC, DONE.
REQ-020 SHALL accept start only in IDLE; start in any other state ignored.
REQ-021 SHALL on accepted start clear accumulators and conversion counter, enter CONV next cycle.
REQ-022 SHALL in CONV drive CNVST_ADC low exactly CNV_CYC cycles, then high and enter WAIT_HI.
REQ-023 SHALL in WAIT_HI wait for BUSY_ADC=1, then WAIT_LO waits for BUSY_ADC=0; each wait has its own BUSY_TMO counter.
REQ-024 SHALL on wait counter reaching BUSY_TMO set timeout, abandon the request (no data_valid), return to IDLE.
REQ-025 SHALL in SHIFT hold CS_ADC low and generate NBITS SCLK periods, each low SCLK_DIV cycles then high SCLK_DIV cycles.
REQ-026 SHALL sample all DOUT_ADC lanes on the CLK edge where SCLK_ADC returns high, MSB first.
REQ-027 SHALL after the NBITS-th high phase raise CS_ADC and enter ACC for one cycle, adding each lane's word, zero-extended, to an NBITS+AVG_LOG2-bit accumulator.
REQ-028 SHALL from ACC return to CONV if fewer than 2^AVG_LOG2 conversions are done, else DONE.
REQ-029 SHALL in DONE load each lane's data with accumulator >> AVG_LOG2 (truncating), pulse data_valid one cycle, go to IDLE.
REQ-030 SHALL hold data unchanged between data_valid pulses, including after a timeout.
REQ-031 SHALL clear timeout only on reset or on the next accepted start.

Reset
REQ-032 SHALL on RST=1 immediately force IDLE, CNVST_ADC=1, CS_ADC=1, SCLK_ADC=1, data=0, data_valid=0, busy=0, timeout=0, all counters and accumulators 0.
REQ-033 SHALL, if RST asserts mid-operation, discard the partial result; start coincident with RST is ignored.

Configuration
REQ-034 SHALL, with macro ADC_AVG_EN defined, average 2^AVG_LOG2 conversions per REQ-027 to REQ-029.
REQ-035 SHALL, without ADC_AVG_EN, ignore AVG_LOG2, use NBITS-bit registers and no accumulator, and output each single conversion directly (ACC to DONE always).

Verification
REQ-036 SHALL cover: NCH=2, NBITS=16, ADC_AVG_EN off, lanes send 0xA5C3/0x1234 -> data=0x1234A5C3, one data_valid pulse.
REQ-037 SHALL cover: ADC_AVG_EN on, AVG_LOG2=2, lane0 sends 100,101,102,103 -> data[15:0]=101; exactly 4 CNVST_ADC low pulses of 4 cycles each.
REQ-038 SHALL cover: BUSY_ADC held 0 after CNVST_ADC, BUSY_TMO=255 -> timeout=1 after 255 WAIT_HI cycles, no data_valid, busy=0; next start clears timeout.
REQ-039 SHALL cover: start pulsed repeatedly during SHIFT -> ignored; exactly one data_valid per accepted start.
REQ-040 SHALL cover: RST asserted mid-SHIFT -> CS_ADC=1, SCLK_ADC=1, busy=0 asynchronously; previous data becomes 0; fresh start completes normally.
REQ-041 SHALL cover: SCLK_DIV=3, NBITS=18 -> SCLK_ADC low 3/high 3 cycles, 18 periods per CS_ADC low window, MSB-first capture of 0x2AAAA.

Source files
------------

// File: rtl/adc_multi_reader.sv
// Multi-lane serial ADC reader: conversion start, BUSY handshake, SCLK shift-in, optional averaging.
// Build with ADC_AVG_EN defined to average 2^AVG_LOG2 conversions per result; otherwise each conversion is output directly.
module adc_multi_reader #(
  parameter int NCH      = 2,
  parameter int NBITS    = 16,
  parameter int SCLK_DIV = 2,
  parameter int CNV_CYC  = 4,
  parameter int BUSY_TMO = 255,
  parameter int AVG_LOG2 = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   start,
  output logic                   CNVST_ADC,
  input  logic                   BUSY_ADC,
  output logic                   CS_ADC,
  output logic                   SCLK_ADC,
  input  logic [NCH-1:0]         DOUT_ADC,
  output logic [NCH*NBITS-1:0]   data,
  output logic                   data_valid,
  output logic                   busy,
  output logic                   timeout
);

  // state   | meaning
  // IDLE    | waiting for start
  // CONV    | CNVST_ADC low for CNV_CYC cycles
  // WAIT_HI | waiting for BUSY_ADC to rise
  // WAIT_LO | waiting for BUSY_ADC to fall
  // SHIFT   | CS_ADC low, NBITS SCLK periods
  // ACC     | fold captured words into the result
  // DONE    | publish data, pulse data_valid
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CONV    = 3'd1;
  localparam logic [2:0] S_WAIT_HI = 3'd2;
  localparam logic [2:0] S_WAIT_LO = 3'd3;
  localparam logic [2:0] S_SHIFT   = 3'd4;
  localparam logic [2:0] S_ACC     = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;
  localparam int CW = 16;

  logic [2:0]                 state_q, state_d;
  logic [CW-1:0]              tmr_q, tmr_d;
  logic [4:0]                 bit_q, bit_d;
  logic                       cnvst_q, cnvst_d;
  logic                       cs_q, cs_d;
  logic                       sclk_q, sclk_d;
  logic                       valid_q, valid_d;
  logic                       tmo_q, tmo_d;
  logic [NCH-1:0][NBITS-1:0]  shreg_q, shreg_d;
  logic [NCH-1:0][NBITS-1:0]  data_q, data_d;
  logic [NCH-1:0][NBITS-1:0]  result;
  logic                       last_conv;

`ifdef ADC_AVG_EN
  localparam int AW    = NBITS + AVG_LOG2;
  localparam int NCONV = 1 << AVG_LOG2;
  logic [NCH-1:0][AW-1:0] acc_q, acc_d;
  logic [4:0]             conv_q, conv_d;

  assign last_conv = (conv_q == 5'(NCONV - 1));
  always_comb begin
    for (int i = 0; i < NCH; i++) result[i] = NBITS'(acc_q[i] >> AVG_LOG2);
  end
`else
  assign last_conv = 1'b1;
  assign result    = shreg_q;
`endif

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    bit_d   = bit_q;
    cnvst_d = cnvst_q;
    cs_d    = cs_q;
    sclk_d  = sclk_q;
    valid_d = 1'b0;
    tmo_d   = tmo_q;
    shreg_d = shreg_q;
    data_d  = data_q;
`ifdef ADC_AVG_EN
    acc_d   = acc_q;
    conv_d  = conv_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          tmo_d   = 1'b0;
          cnvst_d = 1'b0;
          tmr_d   = CW'(CNV_CYC - 1);
          state_d = S_CONV;
`ifdef ADC_AVG_EN
          acc_d   = '0;
          conv_d  = '0;
`endif
        end
      end
      S_CONV: begin
        if (tmr_q == '0) begin
          cnvst_d = 1'b1;
          tmr_d   = CW'(BUSY_TMO - 1);
          state_d = S_WAIT_HI;
        end else tmr_d = tmr_q - 1'b1;
      end
      S_WAIT_HI: begin
        if (BUSY_ADC) begin
          tmr_d   = CW'(BUSY_TMO - 1);
          state_d = S_WAIT_LO;
        end else if (tmr_q == '0) begin
          tmo_d   = 1'b1;
          state_d = S_IDLE;
        end else tmr_d = tmr_q - 1'b1;
      end
      S_WAIT_LO: begin
        if (!BUSY_ADC) begin
          cs_d    = 1'b0;
          sclk_d  = 1'b0;
          tmr_d   = CW'(SCLK_DIV - 1);
          bit_d   = 5'(NBITS - 1);
          state_d = S_SHIFT;
        end else if (tmr_q == '0) begin
          tmo_d   = 1'b1;
          state_d = S_IDLE;
        end else tmr_d = tmr_q - 1'b1;
      end
      S_SHIFT: begin
        // Lanes are captured on the edge that returns SCLK high.
        if (tmr_q != '0) tmr_d = tmr_q - 1'b1;
        else if (!sclk_q) begin
          sclk_d = 1'b1;
          tmr_d  = CW'(SCLK_DIV - 1);
          for (int i = 0; i < NCH; i++) shreg_d[i] = {shreg_q[i][NBITS-2:0], DOUT_ADC[i]};
        end else if (bit_q == '0) begin
          cs_d    = 1'b1;
          state_d = S_ACC;
        end else begin
          sclk_d = 1'b0;
          bit_d  = bit_q - 1'b1;
          tmr_d  = CW'(SCLK_DIV - 1);
        end
      end
      S_ACC: begin
`ifdef ADC_AVG_EN
        for (int i = 0; i < NCH; i++) acc_d[i] = acc_q[i] + AW'(shreg_q[i]);
        conv_d = conv_q + 1'b1;
`endif
        if (last_conv) state_d = S_DONE;
        else begin
          cnvst_d = 1'b0;
          tmr_d   = CW'(CNV_CYC - 1);
          state_d = S_CONV;
        end
      end
      S_DONE: begin
        data_d  = result;
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      bit_q   <= '0;
      cnvst_q <= 1'b1;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b1;
      valid_q <= 1'b0;
      tmo_q   <= 1'b0;
      shreg_q <= '0;
      data_q  <= '0;
`ifdef ADC_AVG_EN
      acc_q   <= '0;
      conv_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      cnvst_q <= cnvst_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      valid_q <= valid_d;
      tmo_q   <= tmo_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
`ifdef ADC_AVG_EN
      acc_q   <= acc_d;
      conv_q  <= conv_d;
`endif
    end
  end

  assign CNVST_ADC  = cnvst_q;
  assign CS_ADC     = cs_q;
  assign SCLK_ADC   = sclk_q;
  assign data       = data_q;
  assign data_valid = valid_q;
  assign busy       = (state_q != S_IDLE);
  assign timeout    = tmo_q;

endmodule

// File: tb/tb_adc_multi_reader.sv
// Scoreboard bench for adc_multi_reader: a 2-lane/16-bit instance and a 1-lane/18-bit SCLK_DIV=3 instance.
module tb_adc_multi_reader;
`ifdef ADC_AVG_EN
  localparam int NC = 4;
  localparam logic [31:0] EXP_AVG = {16'd201, 16'd101};
`else
  localparam int NC = 1;
  localparam logic [31:0] EXP_AVG = {16'd200, 16'd100};
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start0, start1, busy_adc0, busy_adc1;
  logic [1:0] dout0;
  logic [0:0] dout1;
  logic cnvst0, cs0, sclk0, dv0, busy0, tmo0;
  logic cnvst1, cs1, sclk1, dv1, busy1, tmo1;
  logic [31:0] data0;
  logic [17:0] data1;

  adc_multi_reader #(.NCH(2), .NBITS(16), .SCLK_DIV(2), .CNV_CYC(4), .BUSY_TMO(255), .AVG_LOG2(2)) u_dut0 (
    .CLK(clk), .RST(rst), .start(start0), .CNVST_ADC(cnvst0), .BUSY_ADC(busy_adc0), .CS_ADC(cs0),
    .SCLK_ADC(sclk0), .DOUT_ADC(dout0), .data(data0), .data_valid(dv0), .busy(busy0), .timeout(tmo0));

  adc_multi_reader #(.NCH(1), .NBITS(18), .SCLK_DIV(3), .CNV_CYC(4), .BUSY_TMO(255), .AVG_LOG2(0)) u_dut1 (
    .CLK(clk), .RST(rst), .start(start1), .CNVST_ADC(cnvst1), .BUSY_ADC(busy_adc1), .CS_ADC(cs1),
    .SCLK_ADC(sclk1), .DOUT_ADC(dout1), .data(data1), .data_valid(dv1), .busy(busy1), .timeout(tmo1));

  int checks = 0, errors = 0;
  int nvalid0 = 0, nvalid1 = 0;
  int lowrun = 0, npulse = 0, badw = 0;
  logic [31:0] exp0_q[$];
  logic [17:0] exp1_q[$];
  logic [31:0] word0_q[$];
  logic [31:0] sr0;
  logic [17:0] sr1;
  logic [17:0] word1 = 18'h2AAAA;
  logic inhibit0 = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard monitors
  always @(negedge clk) begin
    if (dv0 === 1'b1) begin
      nvalid0++;
      if (exp0_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid0: data 0x%0h, no result expected", data0);
      end else check("data0", data0, exp0_q.pop_front());
    end
    if (dv1 === 1'b1) begin
      nvalid1++;
      if (exp1_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid1: data 0x%0h, no result expected", data1);
      end else check("data1", data1, exp1_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (cnvst0 === 1'b0) lowrun++;
    else if (lowrun != 0) begin
      npulse++;
      if (lowrun != 4) badw++;
      lowrun = 0;
    end
  end

  // ADC models: MSB presented on CS fall, next bit after each SCLK rise
  always @(negedge cs0) begin
    sr0 = (word0_q.size() != 0) ? word0_q.pop_front() : 32'h0;
    dout0 = {sr0[31], sr0[15]};
  end
  always @(posedge sclk0) if (cs0 === 1'b0) begin
    sr0[31:16] = {sr0[30:16], 1'b0};
    sr0[15:0]  = {sr0[14:0], 1'b0};
    dout0 = {sr0[31], sr0[15]};
  end
  always @(negedge cs1) begin
    sr1 = word1;
    dout1 = sr1[17];
  end
  always @(posedge sclk1) if (cs1 === 1'b0) begin
    sr1 = {sr1[16:0], 1'b0};
    dout1 = sr1[17];
  end

  initial begin
    busy_adc0 = 1'b0;
    forever begin
      @(posedge cnvst0);
      if (!inhibit0) begin
        @(negedge clk); busy_adc0 = 1'b1;
        repeat (3) @(negedge clk);
        busy_adc0 = 1'b0;
      end
    end
  end
  initial begin
    busy_adc1 = 1'b0;
    forever begin
      @(posedge cnvst1);
      @(negedge clk); busy_adc1 = 1'b1;
      repeat (3) @(negedge clk);
      busy_adc1 = 1'b0;
    end
  end

  task automatic pulse_start0();
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
  endtask

  task automatic wait_idle0(input string name);
    int n = 0;
    while (busy0 !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
    check(name, busy0, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_cs0();
    int n = 0;
    while (cs0 !== 1'b0 && n < 500) begin @(negedge clk); n++; end
    check("cs0_low_seen", cs0, 1'b0);
  endtask

  initial begin
    int n, hi, run, periods, bw;
    logic prev;
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; dout0 = '0; dout1 = '0;
    repeat (3) @(negedge clk);
    check("rst_cnvst", cnvst0, 1'b1);
    check("rst_cs", cs0, 1'b1);
    check("rst_sclk", sclk0, 1'b1);
    check("rst_data", data0, 32'h0);
    check("rst_flags", {dv0, busy0, tmo0}, 3'b000);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // single result, two lanes
    for (int k = 0; k < NC; k++) word0_q.push_back(32'h1234A5C3);
    exp0_q.push_back(32'h1234A5C3);
    npulse = 0; badw = 0;
    pulse_start0();
    wait_idle0("a_done");
    check("a_nvalid", nvalid0, 1);
    check("a_cnv_pulses", npulse, NC);
    check("a_cnv_width", badw, 0);

    // averaged result
    for (int k = 0; k < NC; k++) word0_q.push_back({16'd200 + 16'(k), 16'd100 + 16'(k)});
    exp0_q.push_back(EXP_AVG);
    npulse = 0; badw = 0;
    pulse_start0();
    wait_idle0("b_done");
    check("b_nvalid", nvalid0, 2);
    check("b_cnv_pulses", npulse, NC);
    check("b_cnv_width", badw, 0);
    check("b_valid_low", dv0, 1'b0);

    // BUSY never rises: timeout after BUSY_TMO cycles in WAIT_HI
    inhibit0 = 1'b1;
    pulse_start0();
    n = 0; hi = 0;
    while (busy0 === 1'b1 && n < 1000) begin
      if (cnvst0 === 1'b1) hi++;
      @(negedge clk); n++;
    end
    check("c_wait_hi_cycles", hi, 255);
    check("c_timeout", tmo0, 1'b1);
    check("c_busy", busy0, 1'b0);
    repeat (3) @(negedge clk);
    check("c_nvalid", nvalid0, 2);
    check("c_data_held", data0, EXP_AVG);
    inhibit0 = 1'b0;
    for (int k = 0; k < NC; k++) word0_q.push_back(32'h00FF8001);
    exp0_q.push_back(32'h00FF8001);
    pulse_start0();
    check("c_timeout_clr", tmo0, 1'b0);
    wait_idle0("c_done");
    check("c_nvalid2", nvalid0, 3);

    // starts during SHIFT are ignored
    for (int k = 0; k < NC; k++) word0_q.push_back(32'hDEADBEEF);
    exp0_q.push_back(32'hDEADBEEF);
    pulse_start0();
    wait_cs0();
    repeat (5) begin
      @(negedge clk) start0 = 1'b1;
      @(negedge clk) start0 = 1'b0;
    end
    wait_idle0("d_done");
    repeat (20) @(negedge clk);
    check("d_no_restart", busy0, 1'b0);
    check("d_nvalid", nvalid0, 4);

    // reset mid-SHIFT
    word0_q.push_back(32'h55550F0F);
    pulse_start0();
    wait_cs0();
    check("e_sclk_low_pre", sclk0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("e_cs", cs0, 1'b1);
    check("e_sclk", sclk0, 1'b1);
    check("e_busy", busy0, 1'b0);
    check("e_data", data0, 32'h0);
    @(negedge clk) rst = 1'b0;
    repeat (10) @(negedge clk);
    for (int k = 0; k < NC; k++) word0_q.push_back(32'h0F0F5555);
    exp0_q.push_back(32'h0F0F5555);
    pulse_start0();
    wait_idle0("e_done");
    check("e_nvalid", nvalid0, 5);

    // 18-bit lane, SCLK_DIV=3
    exp1_q.push_back(18'h2AAAA);
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    n = 0;
    while (cs1 !== 1'b0 && n < 500) begin @(negedge clk); n++; end
    check("f_cs_low_seen", cs1, 1'b0);
    prev = sclk1; run = 0; periods = 0; bw = 0; n = 0;
    while (cs1 === 1'b0 && n < 500) begin
      if (sclk1 === prev) run++;
      else begin
        if (run != 3) bw++;
        if (prev) periods++;
        prev = sclk1; run = 1;
      end
      @(negedge clk); n++;
    end
    if (run != 3) bw++;
    if (prev) periods++;
    check("f_sclk_periods", periods, 18);
    check("f_sclk_phase_width", bw, 0);
    n = 0;
    while (busy1 !== 1'b0 && n < 500) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    check("f_nvalid", nvalid1, 1);

    check("sb0_empty", exp0_q.size(), 0);
    check("sb1_empty", exp1_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "time limit");
  end

endmodule
